// File: rtl/boss_contact_damage.sv
// ---------------------------------------------------------------------------
// boss_contact_damage
//
// Player-vs-boss contact damage for the boss fight.
//
// A registered bounding-box overlap test between the player sprite and the
// boss sprite feeds a small four-state machine:
//   IDLE   - before the first game_start; no damage is taken
//   ALIVE  - a frame tick with contact removes HP
//   INVULN - a post-hit grace window counted in frame ticks
//   DEAD   - HP exhausted; only game_start (or rst) leaves this state
//
// Parameters
//   MAX_HP        player hit points at fight start (fits in 4 bits)
//   CONTACT_DMG   HP removed per contact hit
//   INVULN_FRAMES frame ticks of invulnerability after a hit
//   ENRAGE_HP     boss_hp threshold for doubled damage (enrage build only)
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   frame_tick               one-cycle pulse per video frame
//   game_active[1:0]         2'b01 while the fight is running
//   game_start               one-cycle pulse starting a new fight
//   char_x/char_y            player sprite centre
//   char_hgt/char_lng        player sprite full height / length
//   boss_x/boss_y            boss sprite centre
//   boss_hgt/boss_lng        boss sprite full height / length
//   boss_hp[6:0]             current boss HP (0 means the boss is down)
//   char_hp[3:0]             current player HP
//   char_hit                 one-cycle pulse when damage is applied
//   invuln                   high while invulnerable
//   char_dead                high while dead
//
// Build option
//   BOSS_CONTACT_ENRAGE_EN   when defined, contact damage doubles while
//                            0 < boss_hp <= ENRAGE_HP
// ---------------------------------------------------------------------------
module boss_contact_damage #(
    parameter int MAX_HP        = 8,
    parameter int CONTACT_DMG   = 1,
    parameter int INVULN_FRAMES = 60,
    parameter int ENRAGE_HP     = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [1:0]  game_active,
    input  logic        game_start,
    input  logic [11:0] char_x,
    input  logic [11:0] char_y,
    input  logic [11:0] char_hgt,
    input  logic [11:0] char_lng,
    input  logic [11:0] boss_x,
    input  logic [11:0] boss_y,
    input  logic [11:0] boss_hgt,
    input  logic [11:0] boss_lng,
    input  logic [6:0]  boss_hp,
    output logic [3:0]  char_hp,
    output logic        char_hit,
    output logic        invuln,
    output logic        char_dead
);

    localparam int          CW         = (INVULN_FRAMES > 1) ? $clog2(INVULN_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(INVULN_FRAMES - 1);
    localparam logic [3:0]  HP_START   = 4'(MAX_HP);
    localparam logic [4:0]  DMG_BASE   = 5'(CONTACT_DMG);
    localparam logic [4:0]  DMG_ENRAGE = 5'(2 * CONTACT_DMG);
    localparam logic [7:0]  ENRAGE_LIM = (ENRAGE_HP > 127) ? 8'd127 : 8'(ENRAGE_HP);

`ifdef BOSS_CONTACT_ENRAGE_EN
    localparam bit ENRAGE_BUILD = 1'b1;
`else
    localparam bit ENRAGE_BUILD = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ALIVE, INVULN, DEAD} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      hp_q, hp_d;
    logic            hit_q, hit_d;
    logic            overlap_q, overlap_d;

    // Box overlap on doubled centre distance so full sizes can be used
    // directly; 13 bits hold both 2*|d| and the size sums without wrap.
    logic [11:0] dx, dy;
    logic [12:0] dx2, dy2, sum_lng, sum_hgt;

    assign dx      = (boss_x >= char_x) ? (boss_x - char_x) : (char_x - boss_x);
    assign dy      = (boss_y >= char_y) ? (boss_y - char_y) : (char_y - boss_y);
    assign dx2     = {dx, 1'b0};
    assign dy2     = {dy, 1'b0};
    assign sum_lng = {1'b0, boss_lng} + {1'b0, char_lng};
    assign sum_hgt = {1'b0, boss_hgt} + {1'b0, char_hgt};
    assign overlap_d = (dx2 < sum_lng) && (dy2 < sum_hgt);

    // Damage amount; ENRAGE_BUILD folds to a constant so the default
    // build carries only the base damage path.
    logic       in_enrage;
    logic [4:0] dmg;

    assign in_enrage = (boss_hp != 7'd0) && ({1'b0, boss_hp} <= ENRAGE_LIM);
    assign dmg       = (ENRAGE_BUILD && in_enrage) ? DMG_ENRAGE : DMG_BASE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hp_d    = hp_q;
        hit_d   = 1'b0;

        if (game_start) begin
            // A new fight wins over any frame tick in the same cycle.
            state_d = ALIVE;
            cnt_d   = '0;
            hp_d    = HP_START;
        end else if (game_active == 2'b01) begin
            unique case (state_q)
                ALIVE: begin
                    if (frame_tick && overlap_q && (boss_hp != 7'd0)) begin
                        hit_d   = 1'b1;
                        hp_d    = ({1'b0, hp_q} <= dmg) ? 4'd0 : (hp_q - dmg[3:0]);
                        cnt_d   = CNT_LOAD;
                        state_d = (hp_d == 4'd0) ? DEAD : INVULN;
                    end
                end
                INVULN: begin
                    if (frame_tick) begin
                        if (cnt_q == '0) begin
                            state_d = ALIVE;
                        end else begin
                            cnt_d = cnt_q - 1'b1;
                        end
                    end
                end
                default: begin
                    // IDLE and DEAD hold until game_start
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hp_q      <= HP_START;
            hit_q     <= 1'b0;
            overlap_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hp_q      <= hp_d;
            hit_q     <= hit_d;
            overlap_q <= overlap_d;
        end
    end

    assign char_hp   = hp_q;
    assign char_hit  = hit_q;
    assign invuln    = (state_q == INVULN);
    assign char_dead = (state_q == DEAD);

endmodule

// File: tb/tb_boss_contact_damage.sv
// ---------------------------------------------------------------------------
// tb_boss_contact_damage
//
// Directed scenarios followed by a randomized phase. A behavioural model of
// the player (mode, HP, frames of grace left) is advanced on every clock edge
// from the same inputs the DUT sees and compared against the DUT outputs on
// every falling edge. Directed scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_boss_contact_damage;

    localparam int MAX_HP        = 8;
    localparam int INVULN_FRAMES = 60;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic [1:0]  game_active = 2'b01;
    logic        game_start = 1'b0;
    logic [11:0] char_x = 12'd100, char_y = 12'd400;
    logic [11:0] char_hgt = 12'd48, char_lng = 12'd32;
    logic [11:0] boss_x = 12'd500, boss_y = 12'd400;
    logic [11:0] boss_hgt = 12'd95, boss_lng = 12'd106;
    logic [6:0]  boss_hp = 7'd50;
    logic [3:0]  char_hp;
    logic        char_hit, invuln, char_dead;

    boss_contact_damage dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick),
        .game_active(game_active), .game_start(game_start),
        .char_x(char_x), .char_y(char_y), .char_hgt(char_hgt), .char_lng(char_lng),
        .boss_x(boss_x), .boss_y(boss_y), .boss_hgt(boss_hgt), .boss_lng(boss_lng),
        .boss_hp(boss_hp), .char_hp(char_hp), .char_hit(char_hit),
        .invuln(invuln), .char_dead(char_dead)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit check_en = 1'b0;
    int hit_cnt  = 0;
    int inv_ticks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_IDLE, M_ALIVE, M_INV, M_DEAD} mode_t;
    mode_t m_mode;
    int    m_hp, m_left;
    bit    m_touch, m_hit;

    function automatic int damage_of(input int bhp);
`ifdef BOSS_CONTACT_ENRAGE_EN
        return (bhp > 0 && bhp <= 32) ? 2 : 1;
`else
        return 1;
`endif
    endfunction

    function automatic bit boxes_touch(input int cx, cy, ch, cl, bx, by, bh, bl);
        int adx, ady;
        adx = (bx > cx) ? bx - cx : cx - bx;
        ady = (by > cy) ? by - cy : cy - by;
        return (2 * adx < bl + cl) && (2 * ady < bh + ch);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode  <= M_IDLE;
            m_hp    <= MAX_HP;
            m_left  <= 0;
            m_touch <= 1'b0;
            m_hit   <= 1'b0;
        end else begin : model_step
            mode_t nm;
            int    nh, nl, d;
            bit    nhit;
            nm = m_mode; nh = m_hp; nl = m_left; nhit = 1'b0;
            if (game_start) begin
                nm = M_ALIVE; nh = MAX_HP; nl = 0;
            end else if (game_active == 2'b01) begin
                if (m_mode == M_ALIVE && frame_tick && m_touch && boss_hp != 0) begin
                    d    = damage_of(int'(boss_hp));
                    nh   = (m_hp > d) ? m_hp - d : 0;
                    nhit = 1'b1;
                    nl   = INVULN_FRAMES;
                    nm   = (nh == 0) ? M_DEAD : M_INV;
                end else if (m_mode == M_INV && frame_tick) begin
                    nl = m_left - 1;
                    if (nl == 0) nm = M_ALIVE;
                end
            end
            m_mode  <= nm;
            m_hp    <= nh;
            m_left  <= nl;
            m_hit   <= nhit;
            m_touch <= boxes_touch(int'(char_x), int'(char_y), int'(char_hgt), int'(char_lng),
                                   int'(boss_x), int'(boss_y), int'(boss_hgt), int'(boss_lng));
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("model_char_hp", int'(char_hp), m_hp);
            chk("model_char_hit", int'(char_hit), int'(m_hit));
            chk("model_invuln", int'(invuln), int'(m_mode == M_INV));
            chk("model_char_dead", int'(char_dead), int'(m_mode == M_DEAD));
            if (char_hit)
                $display("hit t=%0t char_hp=%0d boss_hp=%0d", $time, char_hp, boss_hp);
        end
    end

    // ---------------- driver helpers ----------------
    task automatic step(input bit ft, input bit gs);
        frame_tick = ft;
        game_start = gs;
        if (ft && invuln) inv_ticks++;
        @(negedge clk);
        frame_tick = 1'b0;
        game_start = 1'b0;
        if (char_hit) hit_cnt++;
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            step(1'b1, 1'b0);
            step(1'b0, 1'b0);
            step(1'b0, 1'b0);
        end
    endtask

    // New position plus one quiet cycle so the overlap register settles.
    task automatic move(input int x);
        char_x = 12'(x);
        step(1'b0, 1'b0);
    endtask

    task automatic clear_counts();
        hit_cnt = 0;
        inv_ticks = 0;
    endtask

    int hp_before;

    initial begin
        // reset state, asserted from time 0
        @(negedge clk);
        @(negedge clk);
        chk("reset_char_hp", int'(char_hp), 8);
        chk("reset_char_hit", int'(char_hit), 0);
        chk("reset_invuln", int'(invuln), 0);
        chk("reset_char_dead", int'(char_dead), 0);
        rst = 1'b0;
        check_en = 1'b1;
        $display("txn reset done");

        // IDLE takes no damage even while overlapping
        clear_counts();
        move(540);
        frames(5);
        chk("idle_hp", int'(char_hp), 8);
        chk("idle_hits", hit_cnt, 0);
        $display("txn idle overlap hp=%0d hits=%0d", char_hp, hit_cnt);

        // no contact
        move(100);
        step(1'b0, 1'b1);
        clear_counts();
        frames(10);
        chk("nocontact_hp", int'(char_hp), 8);
        chk("nocontact_hits", hit_cnt, 0);
        $display("txn no-contact hp=%0d hits=%0d", char_hp, hit_cnt);

        // single hit and full grace window
        move(540);
        clear_counts();
        frames(1);
        move(100);
        frames(INVULN_FRAMES + 1);
        chk("single_hp", int'(char_hp), 7);
        chk("single_hits", hit_cnt, 1);
        chk("single_inv_ticks", inv_ticks, 60);
        chk("single_invuln_end", int'(invuln), 0);
        $display("txn single-hit hp=%0d hits=%0d inv_ticks=%0d", char_hp, hit_cnt, inv_ticks);

        // edge of overlap: 2*69 equals 106+32 -> no hit, 68 -> hit
        move(500 - 69);
        clear_counts();
        frames(3);
        chk("edge69_hits", hit_cnt, 0);
        move(500 - 68);
        frames(1);
        chk("edge68_hits", hit_cnt, 1);
        chk("edge68_hp", int'(char_hp), 6);
        move(100);
        frames(INVULN_FRAMES + 1);
        $display("txn edge hp=%0d", char_hp);

        // enrage band boss_hp=20
        boss_hp = 7'd20;
        move(540);
        clear_counts();
        frames(1);
`ifdef BOSS_CONTACT_ENRAGE_EN
        chk("enrage_hp", int'(char_hp), 4);
`else
        chk("enrage_hp", int'(char_hp), 5);
`endif
        move(100);
        frames(INVULN_FRAMES + 1);
        boss_hp = 7'd50;
        $display("txn enrage-band hp=%0d", char_hp);

        // paused game freezes and suppresses damage
        game_active = 2'b10;
        hp_before = int'(char_hp);
        move(540);
        clear_counts();
        frames(5);
        chk("freeze_hits", hit_cnt, 0);
        chk("freeze_hp", int'(char_hp), hp_before);
        game_active = 2'b01;
        $display("txn freeze hp=%0d", char_hp);

        // continuous contact until death
        clear_counts();
        frames(400);
        chk("death_hp", int'(char_hp), 0);
        chk("death_dead", int'(char_dead), 1);
        chk("death_invuln", int'(invuln), 0);
        chk("death_hits", hit_cnt, hp_before);
        $display("txn death hits=%0d", hit_cnt);

        // game_start beats a simultaneous frame tick while dead and touching
        clear_counts();
        step(1'b1, 1'b1);
        chk("prio_hp", int'(char_hp), 8);
        chk("prio_dead", int'(char_dead), 0);
        chk("prio_hit", int'(char_hit), 0);
        step(1'b0, 1'b0);
        chk("prio_hit_next", int'(char_hit), 0);
        $display("txn priority hp=%0d", char_hp);

        // asynchronous reset in the middle of a hit pulse
        step(1'b1, 1'b0);
        chk("pre_reset_hit", int'(char_hit), 1);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_hit", int'(char_hit), 0);
        chk("async_reset_invuln", int'(invuln), 0);
        chk("async_reset_hp", int'(char_hp), 8);
        @(negedge clk);
        rst = 1'b0;
        clear_counts();
        frames(4);
        chk("post_reset_hits", hit_cnt, 0);
        chk("post_reset_hp", int'(char_hp), 8);
        $display("txn async-reset hp=%0d hits=%0d", char_hp, hit_cnt);

        // randomized phase
        step(1'b0, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                char_x = 12'(500 + $urandom_range(0, 240) - 120);
                char_y = 12'(400 + $urandom_range(0, 200) - 100);
                char_lng = 12'($urandom_range(0, 80));
                case ($urandom_range(0, 3))
                    0:       boss_hp = 7'd0;
                    1:       boss_hp = 7'($urandom_range(1, 32));
                    default: boss_hp = 7'($urandom_range(33, 127));
                endcase
            end
            game_active = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
        end
        $display("txn random phase done");

        check_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
